if_fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the PC and drives the

---
 rtl/mips_pkg.sv | 13 +
 rtl/if_pc_gen.sv | 28 ++
 rtl/if_fetch_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;
endpackage

// File: rtl/if_pc_gen.sv
// Program counter register: sequential increment, EX redirect, or hold.
module if_pc_gen
  import mips_pkg::PC_STEP;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_q
);
  logic [31:0] pc_d;

  // A flush keeps pc_q so the squashed fetch is reissued from the same point.
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (redirect_valid)      pc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (flush || stall) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, in-flight fetch tracking, imem address mux, IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch/bubble performance counters.
module if_fetch_stage
  import mips_pkg::ifid_t, mips_pkg::PC_STEP;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        req_valid;
  ifid_t       ifid_q;

  if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_q          (pc_q)
  );

  // While stalled the memory re-reads the in-flight address so its data is still valid after.
  assign imem_addr = stall ? req_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc    <= '0;
      req_valid <= 1'b0;
      ifid_q    <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: PC_STEP};
    end else if (redirect_valid || flush) begin
      req_valid    <= 1'b0;
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end else if (!stall) begin
      ifid_q    <= '{valid: req_valid, instr: req_valid ? imem_data : NOP_INSTR,
                     pc: req_pc, pc_plus4: req_pc + PC_STEP};
      req_pc    <= pc_q;
      req_valid <= 1'b1;
    end
  end

  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;

`ifdef IF_PERF_CNT_EN
  logic fetch_evt, bubble_evt;
  assign fetch_evt  = !redirect_valid && !flush && !stall && req_valid;
  assign bubble_evt = redirect_valid || flush || (!stall && !req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (fetch_evt)  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_evt) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  // Counters are absent in this build.
`endif
endmodule
